// File: rtl/skew_buf.sv
// Lane-skewing buffer: stores words FIFO-style, or offsets lane j by j (SKEW) / SIDE_LEN-1-j (DESKEW) entries.
// Latency: 1 cycle push-to-dout. Backpressure: din_rdy from registered count only; held low while a skew tail drains.
module skew_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int SIDE_LEN   = 16,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           Rst,
  input  logic [1:0]                     mode,
  input  logic [SIDE_LEN*DATA_WIDTH-1:0] din,
  input  logic [SIDE_LEN-1:0]            din_lane_en,
  input  logic                           din_vld,
  output logic                           din_rdy,
  input  logic                           din_last,
  output logic [SIDE_LEN*DATA_WIDTH-1:0] dout,
  output logic                           dout_vld,
  input  logic                           dout_rdy,
  output logic                           dout_last
);

  localparam logic [1:0] MODE_FIFO   = 2'd0;
  localparam logic [1:0] MODE_SKEW   = 2'd1;
  localparam logic [1:0] MODE_DESKEW = 2'd2;

  localparam logic [ADDR_WIDTH:0] CNT_DEPTH    = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_SKEW_MAX = (ADDR_WIDTH+1)'(DEPTH - SIDE_LEN);
  localparam logic [ADDR_WIDTH:0] CNT_SIDE     = (ADDR_WIDTH+1)'(SIDE_LEN);
  localparam logic [ADDR_WIDTH:0] CNT_ONE      = (ADDR_WIDTH+1)'(1);

  logic [DEPTH-1:0][SIDE_LEN-1:0][DATA_WIDTH-1:0] mem;
  logic [DEPTH-1:0]      last_q;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic [ADDR_WIDTH:0]   push_inc;
  logic                  tail_pend;
  logic [1:0]            mode_q;
  logic [1:0]            mode_in;
  logic [1:0]            mode_eff;
  logic                  skewed;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [ADDR_WIDTH-1:0] wr_addr [SIDE_LEN];

  // The mode pin only takes effect while the buffer is completely idle.
  always_comb begin
    mode_in  = (mode == 2'd3) ? MODE_FIFO : mode;
    mode_eff = (count == '0 && !tail_pend) ? mode_in : mode_q;
    skewed   = (mode_eff != MODE_FIFO);
    din_rdy  = !tail_pend && (skewed ? (count <= CNT_SKEW_MAX) : (count < CNT_DEPTH));
    dout_vld = (count != '0);
    push     = din_vld && din_rdy;
    pop      = dout_vld && dout_rdy;
    push_inc = '0;
    if (push) push_inc = (din_last && skewed) ? CNT_SIDE : CNT_ONE;
    count_nxt = count + push_inc - {{ADDR_WIDTH{1'b0}}, pop};
    last_addr = skewed ? (wr_ptr + ADDR_WIDTH'(SIDE_LEN - 1)) : wr_ptr;
  end

  always_comb begin
    for (int j = 0; j < SIDE_LEN; j++) begin
      case (mode_eff)
        MODE_SKEW:   wr_addr[j] = wr_ptr + ADDR_WIDTH'(j);
        MODE_DESKEW: wr_addr[j] = wr_ptr + ADDR_WIDTH'(SIDE_LEN - 1 - j);
        default:     wr_addr[j] = wr_ptr;
      endcase
    end
  end

  always_comb begin
    dout      = mem[rd_ptr];
    dout_last = last_q[rd_ptr];
  end

  // A push never targets the entry being popped, so clear-on-pop and lane writes cannot collide.
  always_ff @(posedge clk) begin
    if (!rst_n || Rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      tail_pend <= 1'b0;
      mode_q    <= MODE_FIFO;
      mem       <= '0;
      last_q    <= '0;
    end else begin
      mode_q <= mode_eff;
      count  <= count_nxt;
      if (pop) begin
        rd_ptr         <= rd_ptr + ADDR_WIDTH'(1);
        mem[rd_ptr]    <= '0;
        last_q[rd_ptr] <= 1'b0;
      end
      if (push) begin
        for (int j = 0; j < SIDE_LEN; j++) begin
          mem[wr_addr[j]][j] <= din_lane_en[j] ? din[j*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
        if (din_last) last_q[last_addr] <= 1'b1;
        wr_ptr <= wr_ptr + push_inc[ADDR_WIDTH-1:0];
      end
      if (push && din_last && skewed) tail_pend <= 1'b1;
      else if (count_nxt == '0)       tail_pend <= 1'b0;
    end
  end

endmodule

// File: doc/skew_buf.md
SKEW_BUF -- requirements
Module: skew_buf

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH (default 8), lane width; SIDE_LEN (default 16), lane count; DEPTH (default 32), entries, power of 2 and at least 2*SIDE_LEN; ADDR_WIDTH (default $clog2(DEPTH)).
REQ-002 clk  input  1  single clock; all logic SHALL be rising-edge.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 Rst  input  1  synchronous active-high soft clear, same effect as rst_n.
REQ-005 mode  input  2  transfer mode: 0 FIFO, 1 SKEW, 2 DESKEW; 3 SHALL behave as FIFO.
REQ-006 din  input  SIDE_LEN*DATA_WIDTH  input word, lane j at bits [j*DATA_WIDTH +: DATA_WIDTH].
REQ-007 din_lane_en  input  SIDE_LEN  per-lane write enable; a disabled lane SHALL be stored as zero.
REQ-008 din_vld / din_rdy  input / output  1 each  input handshake.
REQ-009 din_last  input  1  marks the final word of a stream.
REQ-010 dout  output  SIDE_LEN*DATA_WIDTH  output word.
REQ-011 dout_vld / dout_rdy  output / input  1 each  output handshake.
REQ-012 dout_last  output  1  marks the final output word of a stream.

Function
REQ-013 Storage SHALL be a DEPTH x SIDE_LEN register array, every cell reset to zero; wr_ptr and rd_ptr are ADDR_WIDTH bits and wrap modulo DEPTH; count is ADDR_WIDTH+1 bits and holds the number of readable words.
REQ-014 Push SHALL occur when din_vld and din_rdy are both high; pop SHALL occur when dout_vld and dout_rdy are both high.
REQ-015 Lane offset off(j) SHALL be 0 in FIFO, j in SKEW, and SIDE_LEN-1-j in DESKEW.
REQ-016 A push SHALL write lane j to entry (wr_ptr + off(j)) mod DEPTH.
REQ-017 A push SHALL advance wr_ptr by 1 and count by 1, except a push with din_last in SKEW or DESKEW, which SHALL advance both by SIDE_LEN.
REQ-018 The per-entry last flag SHALL be set at entry wr_ptr in FIFO, and at entry wr_ptr+SIDE_LEN-1 in SKEW or DESKEW, when din_last is pushed.
REQ-019 Ready/full rule:
- din_rdy SHALL be (count < DEPTH) in FIFO and (count <= DEPTH-SIDE_LEN) in SKEW or DESKEW;
- din_rdy SHALL be forced low while a SKEW or DESKEW stream tail is pending (last pushed, count > 0);
- din_rdy SHALL be computed from registered count only, with no same-cycle pop bypass.
REQ-020 dout SHALL show the entry at rd_ptr combinationally; dout_vld SHALL equal (count > 0); dout_last SHALL equal that entry's last flag.
REQ-021 A pop SHALL advance rd_ptr by 1, decrement count, and clear the popped entry, data and last flag, to zero in the same cycle.
REQ-022 Lanes never written by the stream SHALL read as zero; this yields zero-filled skew head and tail words.
REQ-023 Latency: a word pushed at edge t SHALL be visible on dout with dout_vld high after edge t, in FIFO mode and for lane 0 in SKEW.
REQ-024 Simultaneous push and pop SHALL both take effect, with count changing by (push increment - 1).
REQ-025 mode SHALL be latched internally only while count is 0 and no tail is pending; mode changes at other times SHALL be ignored until then.
REQ-026 Pushes at full and pops at empty SHALL be impossible by construction, with no pointer or count change.

Reset
REQ-027 While rst_n is low or Rst is high at a clock edge, the block SHALL load:
- wr_ptr = rd_ptr = count = 0;
- tail-pending = 0; latched mode = FIFO;
- all storage cells and last flags = 0.
REQ-028 After reset: dout = 0, dout_vld = 0, dout_last = 0, din_rdy = 1.
REQ-029 Reset asserted mid-stream SHALL discard all contents, with outputs at reset values on the next cycle.

Verification
(All scenarios use SIDE_LEN=4, DEPTH=8, DATA_WIDTH=8.)
REQ-030 FIFO: push 0x01..0x08 with lanes equal to the word value and dout_rdy=0 -> din_rdy drops after the 8th push. Then raise dout_rdy -> words 1..8 pop in order and dout_vld falls after the 8th pop.
REQ-031 SKEW: push A=[a0..a3], then B with din_last, dout_rdy=1 -> 5 output words, lanes listed 0..3:
- [a0,0,0,0]
- [b0,a1,0,0]
- [0,b1,a2,0]
- [0,0,b2,a3]
- [0,0,0,b3] with dout_last=1.
din_rdy SHALL stay low until the 5th pop.
REQ-032 DESKEW: push the same A and B with last -> output lane 3 leads, mirroring REQ-031, with dout_last on the 5th word.
REQ-033 SKEW full: push with dout_rdy=0 -> exactly 5 pushes accepted (count=5 <= 4 fails after the 5th push). Then one pop -> din_rdy high the following cycle.
REQ-034 din_lane_en=4'b0101 in FIFO with din 0xDD in every lane -> output lanes 1 and 3 read 0x00.
REQ-035 Assert Rst after 3 pushes with a mode change pending -> next cycle dout_vld=0, din_rdy=1, and a later FIFO push returns its data with no stale lanes.
